// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8: receive side of an 8-slot time-division link.
// Samples arrive one per in_valid cycle, slot 0 marked by frame_sync.
// Slots 0..6 are parked in a shadow register; the slot-7 sample completes
// the frame, which is then copied into data_out in one step together with
// a one-cycle frame_valid strobe. Framing violations raise sync_err.
module tdm_demux_1_8 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  in_valid,
  input  logic                  frame_sync,
  output logic [8*DATA_W-1:0]   data_out,
  output logic                  frame_valid,
  output logic [2:0]            slot_idx,
  output logic                  locked,
  output logic                  sync_err
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            slot_q, slot_d;
  logic [7*DATA_W-1:0]   shadow_q, shadow_d;
  logic [8*DATA_W-1:0]   data_out_q, data_out_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  sync_err_q, sync_err_d;

  // Shadow lane write request from the framing logic
  logic                  lane_we;
  logic [2:0]            lane_sel;

  // Framing FSM: decides slot advance, lane writes, frame completion and errors
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    data_out_d    = data_out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    lane_we       = 1'b0;
    lane_sel      = 3'd0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // Only a marked sample can start a frame; everything else is dropped quietly
          if (frame_sync) begin
            lane_we  = 1'b1;
            lane_sel = 3'd0;
            slot_d   = 3'd1;
            state_d  = COLLECT;
          end
        end
        COLLECT: begin
          if (frame_sync) begin
            // Sync at slot 0 is a normal back-to-back frame start; anywhere else
            // it aborts the partial frame but is still accepted as the new slot 0
            sync_err_d = (slot_q != 3'd0);
            lane_we    = 1'b1;
            lane_sel   = 3'd0;
            slot_d     = 3'd1;
          end else if (slot_q == 3'd0) begin
            // Expected a frame start and did not get one: drop lock
            sync_err_d = 1'b1;
            slot_d     = 3'd0;
            state_d    = HUNT;
          end else if (slot_q == 3'd7) begin
            // Last slot goes straight to the output; lanes 0..6 come from shadow
            data_out_d    = {data_in, shadow_q};
            frame_valid_d = 1'b1;
            slot_d        = 3'd0;
          end else begin
            lane_we  = 1'b1;
            lane_sel = slot_q;
            slot_d   = slot_q + 3'd1;
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  // Per-lane shadow next-state: a lane only changes when it is the selected slot
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_lane
      assign shadow_d[gi*DATA_W +: DATA_W] =
        (lane_we && (lane_sel == 3'(gi))) ? data_in : shadow_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // State, counters, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 3'd0;
      shadow_q      <= '0;
      data_out_q    <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      data_out_q    <= data_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign frame_valid = frame_valid_q;
  assign slot_idx    = slot_q;
  assign locked      = (state_q == COLLECT);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Directed bench for tdm_demux_1_8: a DATA_W=1 instance for framing
// scenarios and a DATA_W=4 instance for wide lanes and async reset.
module tb_tdm_demux_1_8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DATA_W = 1 instance
  logic        rst1_n, v1, fs1;
  logic [0:0]  din1;
  logic [7:0]  dout1;
  logic        fv1, lk1, se1;
  logic [2:0]  slot1;

  // DATA_W = 4 instance
  logic        rst4_n, v4, fs4;
  logic [3:0]  din4;
  logic [31:0] dout4;
  logic        fv4, lk4, se4;
  logic [2:0]  slot4;

  int vectors = 0;
  int miscompares = 0;

  tdm_demux_1_8 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .data_in(din1), .in_valid(v1), .frame_sync(fs1),
    .data_out(dout1), .frame_valid(fv1), .slot_idx(slot1), .locked(lk1), .sync_err(se1)
  );

  tdm_demux_1_8 #(.DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .data_in(din4), .in_valid(v4), .frame_sync(fs4),
    .data_out(dout4), .frame_valid(fv4), .slot_idx(slot4), .locked(lk4), .sync_err(se4)
  );

  // Inputs change on the falling edge; outputs of the previous rising edge
  // are stable at that moment and are checked there.
  task automatic drive1(input logic v, input logic fs, input logic d);
    @(negedge clk);
    v1 = v; fs1 = fs; din1 = d;
  endtask

  task automatic drive4(input logic v, input logic fs, input logic [3:0] d);
    @(negedge clk);
    v4 = v; fs4 = fs; din4 = d;
  endtask

  task automatic test_reset;
    rst1_n = 1'b0; rst4_n = 1'b0;
    v1 = 0; fs1 = 0; din1 = 0;
    v4 = 0; fs4 = 0; din4 = 0;
    repeat (2) @(negedge clk);
    if (dout1 !== 8'h00) begin $display("FAIL reset_dout1 got=%h exp=00", dout1); miscompares++; end vectors++;
    if (fv1 !== 1'b0) begin $display("FAIL reset_fv1 got=%b exp=0", fv1); miscompares++; end vectors++;
    if (slot1 !== 3'd0) begin $display("FAIL reset_slot1 got=%0d exp=0", slot1); miscompares++; end vectors++;
    if (lk1 !== 1'b0) begin $display("FAIL reset_locked1 got=%b exp=0", lk1); miscompares++; end vectors++;
    if (se1 !== 1'b0) begin $display("FAIL reset_syncerr1 got=%b exp=0", se1); miscompares++; end vectors++;
    if (dout4 !== 32'h0) begin $display("FAIL reset_dout4 got=%h exp=0", dout4); miscompares++; end vectors++;
    rst1_n = 1'b1; rst4_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset: both instances idle in HUNT");
  endtask

  task automatic test_single_frame;
    logic [7:0] f = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      drive1(1'b1, k == 0, f[k]);
      if (k > 0 && fv1 !== 1'b0) begin $display("FAIL single_early_fv slot=%0d got=%b exp=0", k, fv1); miscompares++; end
      if (k > 0) vectors++;
    end
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b1) begin $display("FAIL single_fv got=%b exp=1", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'h4D) begin $display("FAIL single_dout got=%h exp=4d", dout1); miscompares++; end vectors++;
    if (lk1 !== 1'b1) begin $display("FAIL single_locked got=%b exp=1", lk1); miscompares++; end vectors++;
    if (slot1 !== 3'd0) begin $display("FAIL single_slot got=%0d exp=0", slot1); miscompares++; end vectors++;
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b0) begin $display("FAIL single_fv_pulse got=%b exp=0", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'h4D) begin $display("FAIL single_hold got=%h exp=4d", dout1); miscompares++; end vectors++;
    $display("single frame: data_out=%h", dout1);
  endtask

  task automatic test_gap;
    logic [7:0] f = 8'h4D;
    for (int k = 0; k < 4; k++) drive1(1'b1, k == 0, f[k]);
    for (int g = 0; g < 3; g++) begin
      drive1(1'b0, 1'b0, 1'b0);
      if (slot1 !== 3'd4) begin $display("FAIL gap_slot cyc=%0d got=%0d exp=4", g, slot1); miscompares++; end vectors++;
      if (fv1 !== 1'b0) begin $display("FAIL gap_fv cyc=%0d got=%b exp=0", g, fv1); miscompares++; end vectors++;
    end
    for (int k = 4; k < 8; k++) drive1(1'b1, 1'b0, f[k]);
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b1) begin $display("FAIL gap_fv_end got=%b exp=1", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'h4D) begin $display("FAIL gap_dout got=%h exp=4d", dout1); miscompares++; end vectors++;
    $display("gapped frame: data_out=%h", dout1);
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits = {8'h3C, 8'hA5};
    for (int i = 0; i < 16; i++) begin
      drive1(1'b1, (i % 8) == 0, bits[i]);
      if (se1 !== 1'b0) begin $display("FAIL b2b_syncerr i=%0d got=%b exp=0", i, se1); miscompares++; end vectors++;
      if (i == 8) begin
        if (fv1 !== 1'b1) begin $display("FAIL b2b_fv1 got=%b exp=1", fv1); miscompares++; end vectors++;
        if (dout1 !== 8'hA5) begin $display("FAIL b2b_dout1 got=%h exp=a5", dout1); miscompares++; end vectors++;
      end else if (i > 0) begin
        if (fv1 !== 1'b0) begin $display("FAIL b2b_fv_idle i=%0d got=%b exp=0", i, fv1); miscompares++; end vectors++;
      end
    end
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b1) begin $display("FAIL b2b_fv2 got=%b exp=1", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'h3C) begin $display("FAIL b2b_dout2 got=%h exp=3c", dout1); miscompares++; end vectors++;
    if (se1 !== 1'b0) begin $display("FAIL b2b_syncerr_end got=%b exp=0", se1); miscompares++; end vectors++;
    $display("back-to-back: frames a5 then %h", dout1);
  endtask

  task automatic test_early_sync;
    drive1(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 5; k++) drive1(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive1(1'b1, k == 0, 1'b1);
      if (k == 0) begin
        if (slot1 !== 3'd5) begin $display("FAIL early_slot_before got=%0d exp=5", slot1); miscompares++; end vectors++;
      end
      if (k == 1) begin
        if (se1 !== 1'b1) begin $display("FAIL early_syncerr got=%b exp=1", se1); miscompares++; end vectors++;
        if (fv1 !== 1'b0) begin $display("FAIL early_fv got=%b exp=0", fv1); miscompares++; end vectors++;
        if (slot1 !== 3'd1) begin $display("FAIL early_slot got=%0d exp=1", slot1); miscompares++; end vectors++;
        if (dout1 !== 8'h3C) begin $display("FAIL early_dout_kept got=%h exp=3c", dout1); miscompares++; end vectors++;
        if (lk1 !== 1'b1) begin $display("FAIL early_locked got=%b exp=1", lk1); miscompares++; end vectors++;
      end
      if (k == 2) begin
        if (se1 !== 1'b0) begin $display("FAIL early_syncerr_pulse got=%b exp=0", se1); miscompares++; end vectors++;
      end
    end
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b1) begin $display("FAIL early_fv_ff got=%b exp=1", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'hFF) begin $display("FAIL early_dout_ff got=%h exp=ff", dout1); miscompares++; end vectors++;
    $display("early sync: recovered frame %h", dout1);
  endtask

  task automatic test_lost_sync;
    logic [7:0] f = 8'h81;
    drive1(1'b1, 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0);
    if (se1 !== 1'b1) begin $display("FAIL lost_syncerr got=%b exp=1", se1); miscompares++; end vectors++;
    if (lk1 !== 1'b0) begin $display("FAIL lost_locked got=%b exp=0", lk1); miscompares++; end vectors++;
    if (slot1 !== 3'd0) begin $display("FAIL lost_slot got=%0d exp=0", slot1); miscompares++; end vectors++;
    if (fv1 !== 1'b0) begin $display("FAIL lost_fv got=%b exp=0", fv1); miscompares++; end vectors++;
    drive1(1'b1, 1'b0, 1'b1);
    if (se1 !== 1'b0) begin $display("FAIL lost_syncerr_pulse got=%b exp=0", se1); miscompares++; end vectors++;
    drive1(1'b1, 1'b0, 1'b0);
    if (lk1 !== 1'b0 || slot1 !== 3'd0 || se1 !== 1'b0) begin
      $display("FAIL lost_hunt_ignore got=lk%b/slot%0d/se%b exp=lk0/slot0/se0", lk1, slot1, se1); miscompares++;
    end vectors++;
    for (int k = 0; k < 8; k++) drive1(1'b1, k == 0, f[k]);
    drive1(1'b0, 1'b0, 1'b0);
    if (fv1 !== 1'b1) begin $display("FAIL lost_fv_81 got=%b exp=1", fv1); miscompares++; end vectors++;
    if (dout1 !== 8'h81) begin $display("FAIL lost_dout_81 got=%h exp=81", dout1); miscompares++; end vectors++;
    $display("lost sync: relocked, frame %h", dout1);
  endtask

  task automatic test_wide_async_reset;
    for (int k = 0; k < 8; k++) drive4(1'b1, k == 0, 4'(k));
    drive4(1'b0, 1'b0, 4'h0);
    if (fv4 !== 1'b1) begin $display("FAIL wide_fv got=%b exp=1", fv4); miscompares++; end vectors++;
    if (dout4 !== 32'h76543210) begin $display("FAIL wide_dout got=%h exp=76543210", dout4); miscompares++; end vectors++;
    for (int k = 0; k < 4; k++) drive4(1'b1, k == 0, 4'hA);
    drive4(1'b0, 1'b0, 4'h0);
    if (slot4 !== 3'd4 || lk4 !== 1'b1) begin
      $display("FAIL wide_partial got=slot%0d/lk%b exp=slot4/lk1", slot4, lk4); miscompares++;
    end vectors++;
    rst4_n = 1'b0;
    #1;
    if (dout4 !== 32'h0) begin $display("FAIL wide_rst_dout got=%h exp=0", dout4); miscompares++; end vectors++;
    if (lk4 !== 1'b0) begin $display("FAIL wide_rst_locked got=%b exp=0", lk4); miscompares++; end vectors++;
    if (slot4 !== 3'd0) begin $display("FAIL wide_rst_slot got=%0d exp=0", slot4); miscompares++; end vectors++;
    @(negedge clk);
    rst4_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive4(1'b0, 1'b0, 4'h0);
      if (fv4 !== 1'b0 || dout4 !== 32'h0) begin
        $display("FAIL wide_after_rst cyc=%0d got=fv%b/%h exp=fv0/00000000", c, fv4, dout4); miscompares++;
      end vectors++;
    end
    for (int k = 0; k < 8; k++) drive4(1'b1, k == 0, 4'(k + 8));
    drive4(1'b0, 1'b0, 4'h0);
    if (fv4 !== 1'b1) begin $display("FAIL wide_fv2 got=%b exp=1", fv4); miscompares++; end vectors++;
    if (dout4 !== 32'hFEDCBA98) begin $display("FAIL wide_dout2 got=%h exp=fedcba98", dout4); miscompares++; end vectors++;
    $display("wide: frame %h after reset recovery", dout4);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gap();
    test_back_to_back();
    test_early_sync();
    test_lost_sync();
    test_wide_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
